// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid: valid/ready pipeline register, 2-entry skid, flush count |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W+1:0] c_drop_max = {2'b00, {CNT_W{1'b1}}};

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_drop;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [1:0]        w_occ;
  logic [1:0]        w_drop_add;
  logic [CNT_W+1:0]  w_drop_sum;
  logic [CNT_W-1:0]  w_drop_next;

  assign w_occ      = r_state;
  assign in_ready   = (r_state != S_FULL);
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // A head delivered in the flush cycle is not counted as dropped.
  assign w_drop_add  = w_occ - {1'b0, w_out_fire};
  assign w_drop_sum  = {2'b00, r_drop} + {{CNT_W{1'b0}}, w_drop_add};
  assign w_drop_next = (w_drop_sum > c_drop_max) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
      r_drop  <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
      r_drop  <= w_drop_next;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_main  <= in_data;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_skid  <= in_data;
            r_state <= S_FULL;
          end else if (w_out_fire) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign out_data   = r_main;
  assign occupancy  = w_occ;
  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_skid: directed vector table plus FIFO-order scoreboard run  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam logic [63:0] c_rv = 64'hA5A5_0000_0000_5A5A;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [1:0]  occupancy;
  logic [7:0]  drop_count;
  logic        in_ready2, out_valid2;
  logic [63:0] out_data2;
  logic [1:0]  occupancy2;
  logic [1:0]  drop_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(64), .RESET_VAL(c_rv), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  pipe_stage_skid #(.DATA_W(64), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .occupancy(occupancy2), .drop_count(drop_count2)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        ev;
    logic [63:0] ed;
    logic [1:0]  eocc;
    logic        eir;
    logic [7:0]  edrop;
    logic [1:0]  edrop2;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic fl, logic iv, logic [63:0] id, logic ordy,
                              logic ev, logic [63:0] ed, logic [1:0] eocc,
                              logic [7:0] edrop, logic [1:0] edrop2);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.eocc = eocc; v.eir = (eocc != 2'd2);
    v.edrop = edrop; v.edrop2 = edrop2;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sdat(int k);
    logic [31:0] hi;
    hi = 32'(k);
    return {hi, 32'h0000_0013};
  endfunction

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    int          sent, recv, cyc;
    logic        ifire, ofire;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    //   rst fl iv data          ordy  ev data           occ drop d2
    add(1, 0, 0, 64'h0,         0,    0, c_rv,          0,  0,   0);
    for (int k = 0; k <= 12; k++)
      add(0, 0, 1, sdat(k),     1,    1, sdat(k),       1,  0,   0);
    add(0, 0, 0, 64'h0,         1,    0, sdat(12),      0,  0,   0);
    // stall with two entries, then drain
    add(0, 0, 1, 64'h1111,      0,    1, 64'h1111,      1,  0,   0);
    add(0, 0, 1, 64'h2222,      0,    1, 64'h1111,      2,  0,   0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 64'hBEEF,    0,    1, 64'h1111,      2,  0,   0);
    add(0, 0, 0, 64'h0,         1,    1, 64'h2222,      1,  0,   0);
    add(0, 0, 0, 64'h0,         1,    0, 64'h2222,      0,  0,   0);
    // flush from FULL with C offered
    add(0, 0, 1, 64'h1111,      0,    1, 64'h1111,      1,  0,   0);
    add(0, 0, 1, 64'h2222,      0,    1, 64'h1111,      2,  0,   0);
    add(0, 1, 1, 64'h3333,      0,    0, 64'h1111,      0,  2,   2);
    add(0, 0, 0, 64'h0,         1,    0, 64'h1111,      0,  2,   2);
    // flush from ONE while delivering, then FULL while delivering
    add(0, 0, 1, 64'h4444,      0,    1, 64'h4444,      1,  2,   2);
    add(0, 1, 0, 64'h0,         1,    0, 64'h4444,      0,  2,   2);
    add(0, 0, 1, 64'h5555,      0,    1, 64'h5555,      1,  2,   2);
    add(0, 0, 1, 64'h6666,      0,    1, 64'h5555,      2,  2,   2);
    add(0, 1, 0, 64'h0,         1,    0, 64'h5555,      0,  3,   3);
    // saturation: three full flushes after reset
    add(1, 0, 0, 64'h0,         0,    0, c_rv,          0,  0,   0);
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 1, 64'h7001 + 64'(2*k), 0, 1, 64'h7001 + 64'(2*k), 1, 8'(2*k), (k == 0) ? 2'd0 : (k == 1) ? 2'd2 : 2'd3);
      add(0, 0, 1, 64'h7002 + 64'(2*k), 0, 1, 64'h7001 + 64'(2*k), 2, 8'(2*k), (k == 0) ? 2'd0 : (k == 1) ? 2'd2 : 2'd3);
      add(0, 1, 0, 64'h0,               0, 0, 64'h7001 + 64'(2*k), 0, 8'(2*k+2), (k == 0) ? 2'd2 : 2'd3);
    end
    // reset wins over flush and handshakes
    add(0, 0, 1, 64'h8001,      0,    1, 64'h8001,      1,  6,   3);
    add(0, 0, 1, 64'h8002,      0,    1, 64'h8001,      2,  6,   3);
    add(1, 1, 1, 64'h8003,      1,    0, c_rv,          0,  0,   0);
    add(0, 0, 0, 64'h0,         0,    0, c_rv,          0,  0,   0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; flush = vecs[i].fl; in_valid = vecs[i].iv;
      in_data = vecs[i].id; out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d out_data", i), out_data, vecs[i].ed);
      chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vecs[i].eocc));
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].eir));
      chk($sformatf("v%0d drop_count", i), 64'(drop_count), 64'(vecs[i].edrop));
      chk($sformatf("v%0d drop_count_w2", i), 64'(drop_count2), 64'(vecs[i].edrop2));
    end

    // FIFO order under irregular back-pressure
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 20 && cyc < 400) begin
      in_valid  = (sent < 20);
      in_data   = 64'hF000 + 64'(sent);
      out_ready = ($urandom_range(2) != 0);
      #1;
      ifire = in_valid & in_ready;
      ofire = out_valid & out_ready;
      if (ofire) begin
        if (exp_q.size() == 0) begin
          chk("order underflow", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_v = exp_q.pop_front();
          chk($sformatf("order item %0d", recv), out_data, exp_v);
        end
        recv++;
      end
      if (ifire) begin
        exp_q.push_back(in_data);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("order received count", 64'(recv), 64'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
